// File: rtl/imem_loader_if.sv
// Byte stream in from UART RX plus the instruction RAM write port.
// master = loader side, slave = UART/RAM side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed UART bytes -> big-endian words -> instruction RAM; write strobe one cycle after the 4th byte.
// Takes a byte every cycle while loading (rx_ready=1); refuses bytes in DONE/ERROR until restart.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  input  logic          restart,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_index;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic [7:0]  acc;
  logic [23:0] tmo;
  logic        wr_pend;
  logic [31:0] wr_word;
  logic [31:0] wr_addr;

  logic        accept;
  logic [15:0] len_w;
  logic [31:0] word_addr;
  logic        tmo_active;

  assign accept     = bus.rx_valid & bus.rx_ready;
  assign len_w      = {len_hi, bus.rx_data};
  assign word_addr  = BASE_ADDR + {14'd0, word_index, 2'b00};
  assign tmo_active = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CSUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.rx_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= 32'd0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'b00;
      len_hi        <= 8'd0;
      len           <= 16'd0;
      word_index    <= 16'd0;
      byte_cnt      <= 2'd0;
      shreg         <= 24'd0;
      acc           <= 8'd0;
      tmo           <= 24'd0;
      wr_pend       <= 1'b0;
      wr_word       <= 32'd0;
      wr_addr       <= 32'd0;
    end else begin
      // Assembled word is staged one cycle so the strobe lands after edge N+1.
      bus.mem_we <= 1'b0;
      if (wr_pend) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= wr_addr;
        bus.mem_wdata <= wr_word;
        wr_pend       <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept && bus.rx_data == 8'hA5) begin
            state      <= S_LEN_HI;
            acc        <= 8'd0;
            word_index <= 16'd0;
            byte_cnt   <= 2'd0;
            tmo        <= 24'd0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= bus.rx_data;
            acc    <= acc ^ bus.rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len <= len_w;
            acc <= acc ^ bus.rx_data;
            if ({1'b0, len_w} > MAX_LEN) begin
              state        <= S_ERROR;
              error        <= 1'b1;
              err_code     <= 2'b11;
              bus.rx_ready <= 1'b0;
            end else if (len_w == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            acc      <= acc ^ bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {shreg[15:0], bus.rx_data};
            if (byte_cnt == 2'd3) begin
              wr_pend    <= 1'b1;
              wr_word    <= {shreg, bus.rx_data};
              wr_addr    <= word_addr;
              word_index <= word_index + 16'd1;
              if (word_index == len - 16'd1)
                state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'b01;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            state        <= S_IDLE;
            bus.rx_ready <= 1'b1;
            bus.mem_addr <= BASE_ADDR;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
            word_index   <= 16'd0;
            byte_cnt     <= 2'd0;
            acc          <= 8'd0;
            tmo          <= 24'd0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // An accepted byte always beats an expiring timeout on the same edge.
      if (tmo_active) begin
        if (accept) begin
          tmo <= 24'd0;
        end else if (tmo == TIMEOUT_CYCLES - 24'd1) begin
          tmo          <= 24'd0;
          state        <= S_ERROR;
          error        <= 1'b1;
          err_code     <= 2'b10;
          bus.rx_ready <= 1'b0;
        end else begin
          tmo <= tmo + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum/timeout/length errors, restart and async reset.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic       cpu_hold, done, error;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(4),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .restart(restart),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  logic [31:0] waddr[$];
  logic [31:0] wdata[$];
  logic        prev_we = 1'b0;
  int          long_we = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      waddr.push_back(bus.mem_addr);
      wdata.push_back(bus.mem_wdata);
      if (prev_we) long_we++;
    end
    prev_we = (bus.mem_we === 1'b1);
  end

  logic [7:0] txq[$];

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_q();
    foreach (txq[i]) send_byte(txq[i]);
  endtask

  task automatic clear_log();
    waddr.delete();
    wdata.delete();
    long_we = 0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    restart = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rx_ready, bus.mem_we, cpu_hold, done, error, err_code} !== 7'b1_0_1_0_0_00) begin
      errors++;
      $display("FAIL reset_flags got %b want 1010000",
               {bus.rx_ready, bus.mem_we, cpu_hold, done, error, err_code});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus addr %h data %h want 0 0", bus.mem_addr, bus.mem_wdata);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Checksum 00^02^3C^10^40^00^20^11^00^01 = 5E.
  task automatic test_good_frame();
    pulse_restart();
    clear_log();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h10, 8'h40, 8'h00,
            8'h20, 8'h11, 8'h00, 8'h01, 8'h5E};
    send_q();
    checks++;
    if ({done, cpu_hold, bus.rx_ready} !== 3'b100) begin
      errors++;
      $display("FAIL good_status done/hold/ready got %b want 100", {done, cpu_hold, bus.rx_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (waddr.size() !== 2) begin
      errors++;
      $display("FAIL good_wcount got %0d want 2", waddr.size());
    end
    checks++;
    if ((waddr.size() > 0 ? {waddr[0], wdata[0]} : 64'hx) !== {32'h0, 32'h3C104000}) begin
      errors++;
      $display("FAIL good_word0 got %h want 000000003c104000",
               waddr.size() > 0 ? {waddr[0], wdata[0]} : 64'hx);
    end
    checks++;
    if ((waddr.size() > 1 ? {waddr[1], wdata[1]} : 64'hx) !== {32'h4, 32'h20110001}) begin
      errors++;
      $display("FAIL good_word1 got %h want 0000000420110001",
               waddr.size() > 1 ? {waddr[1], wdata[1]} : 64'hx);
    end
    checks++;
    if (long_we !== 0) begin
      errors++;
      $display("FAIL good_we_width got %0d multi-cycle strobes want 0", long_we);
    end
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b0, 32'h4, 32'h20110001}) begin
      errors++;
      $display("FAIL good_hold we/addr/data got %b %h %h want 0 4 20110001",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_restart();
    clear_log();
    checks++;
    if ({bus.mem_addr, done, cpu_hold, bus.rx_ready} !== {32'h0, 3'b011}) begin
      errors++;
      $display("FAIL restart_done addr %h done/hold/ready %b want 0 011",
               bus.mem_addr, {done, cpu_hold, bus.rx_ready});
    end
    txq = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h10, 8'h40, 8'h00,
            8'h20, 8'h11, 8'h00, 8'h01, 8'h48};
    send_q();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({error, err_code, cpu_hold, bus.rx_ready, done} !== 6'b1_01_1_0_0) begin
      errors++;
      $display("FAIL csum_status err/code/hold/ready/done got %b want 101100",
               {error, err_code, cpu_hold, bus.rx_ready, done});
    end
    checks++;
    if (waddr.size() !== 2 || long_we !== 0) begin
      errors++;
      $display("FAIL csum_writes got %0d writes %0d long want 2 0", waddr.size(), long_we);
    end
    // A5 presented with restart must be dropped, so 00 00 00 afterwards is noise in IDLE.
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    restart      = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    restart      = 1'b0;
    txq = '{8'h00, 8'h00, 8'h00};
    send_q();
    checks++;
    if ({done, error, bus.rx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL restart_byte_dropped done/err/ready got %b want 001", {done, error, bus.rx_ready});
    end
  endtask

  task automatic test_timeout();
    pulse_restart();
    clear_log();
    txq = '{8'hA5, 8'h00, 8'h01, 8'h3C};
    send_q();
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early error got %b want 0 at 15 cycles", error);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({error, err_code, bus.rx_ready, cpu_hold} !== 5'b1_10_0_1) begin
      errors++;
      $display("FAIL timeout_fire err/code/ready/hold got %b want 11001",
               {error, err_code, bus.rx_ready, cpu_hold});
    end
    checks++;
    if (waddr.size() !== 0) begin
      errors++;
      $display("FAIL timeout_nowrite got %0d writes want 0", waddr.size());
    end
  endtask

  // Recovery frame checksum 00^01^DE^AD^BE^EF = 23.
  task automatic test_length_overflow();
    pulse_restart();
    clear_log();
    txq = '{8'hA5, 8'h00, 8'h05};
    send_q();
    checks++;
    if ({error, err_code, bus.rx_ready} !== 4'b1_11_0) begin
      errors++;
      $display("FAIL len_overflow err/code/ready got %b want 1110", {error, err_code, bus.rx_ready});
    end
    pulse_restart();
    checks++;
    if ({error, err_code, done, cpu_hold, bus.rx_ready} !== 6'b0_00_0_1_1) begin
      errors++;
      $display("FAIL len_restart err/code/done/hold/ready got %b want 000011",
               {error, err_code, done, cpu_hold, bus.rx_ready});
    end
    txq = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    send_q();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (waddr.size() !== 1 || (waddr.size() > 0 ? {waddr[0], wdata[0]} : 64'hx) !== {32'h0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL len_reload got %0d writes first %h want 1 00000000deadbeef",
               waddr.size(), waddr.size() > 0 ? {waddr[0], wdata[0]} : 64'hx);
    end
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL len_reload_done done/err/hold got %b want 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_zero_length();
    pulse_restart();
    clear_log();
    txq = '{8'h7F, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL zero_len done/err/hold got %b want 100", {done, error, cpu_hold});
    end
    checks++;
    if (waddr.size() !== 0) begin
      errors++;
      $display("FAIL zero_len_nowrite got %0d writes want 0", waddr.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse_restart();
    clear_log();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h10, 8'h40, 8'h00, 8'h20, 8'h11};
    send_q();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.rx_ready, bus.mem_we, cpu_hold, done, error, err_code, bus.mem_addr, bus.mem_wdata}
        !== {7'b1_0_1_0_0_00, 64'd0}) begin
      errors++;
      $display("FAIL midreset_outputs got %b %h %h want 1010000 0 0",
               {bus.rx_ready, bus.mem_we, cpu_hold, done, error, err_code},
               bus.mem_addr, bus.mem_wdata);
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (waddr.size() !== 1 || (waddr.size() > 0 ? wdata[0] : 32'hx) !== 32'h3C104000) begin
      errors++;
      $display("FAIL midreset_writes got %0d writes want 1 of 3c104000", waddr.size());
    end
    clear_log();
    txq = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h10, 8'h40, 8'h00,
            8'h20, 8'h11, 8'h00, 8'h01, 8'h5E};
    send_q();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (waddr.size() !== 2 || (waddr.size() > 1 ? {waddr[0], waddr[1]} : 64'hx) !== {32'h0, 32'h4}
        || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reload got %0d writes done %b want 2 writes at 0,4 done 1",
               waddr.size(), done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_length_overflow();
    test_zero_length();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
